// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch and data ports.
// Optional memory-ack timeout with error reporting is enabled by defining MEMARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned STARVE_MAX  = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic            clk_i,
    input  logic            reset_i,

    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [DW-1:0]   if_rdata_o,

    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_wdata_i,
    input  logic [DW/8-1:0] d_wstrb_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [DW-1:0]   d_rdata_o,

    output logic            m_req_o,
    output logic            m_we_o,
    output logic [AW-1:0]   m_addr_o,
    output logic [DW-1:0]   m_wdata_o,
    output logic [DW/8-1:0] m_wstrb_o,
    input  logic            m_ack_i,
    input  logic [DW-1:0]   m_rdata_i,

    output logic            err_o,
    output logic            err_sticky_o
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = 4;

    if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 1 || (DW % 8) != 0) begin : g_bad_param
        $error("mem_port_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic            m_req_q, m_req_d;
    logic            m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;
    logic [SW-1:0]   m_wstrb_q, m_wstrb_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;

    logic            fetch_wins;
    logic            tmo_evt;
    logic            done_evt;

    // Data has default priority; a fetch that has lost STARVE_MAX times in a row wins.
    assign fetch_wins = if_req_i && (!d_req_i || (starve_q == CW'(STARVE_MAX)));
    assign if_gnt_o   = (state_q == IDLE) && fetch_wins;
    assign d_gnt_o    = (state_q == IDLE) && d_req_i && !fetch_wins;
    assign done_evt   = m_ack_i || tmo_evt;

`ifdef MEMARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          err_sticky_q, err_sticky_d;

    // Counts un-acked BUSY cycles; the last allowed cycle without ack aborts the access.
    assign tmo_evt = (state_q != IDLE) && !m_ack_i && (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_d        = tmo_q;
        err_d        = tmo_evt;
        err_sticky_d = err_sticky_q | tmo_evt;
        if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (!m_ack_i) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tmo_q        <= '0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_o        = err_q;
    assign err_sticky_o = err_sticky_q;
`else
    assign tmo_evt      = 1'b0;
    assign err_o        = 1'b0;
    assign err_sticky_o = 1'b0;
`endif

    // Next-state, payload latch and response generation.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_wstrb_d   = m_wstrb_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_gnt_o) begin
                    state_d   = BUSY_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr_i;
                    m_wdata_d = '0;
                    m_wstrb_d = '0;
                    starve_d  = '0;
                end else if (d_gnt_o) begin
                    state_d   = BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we_i;
                    m_addr_d  = d_addr_i;
                    m_wdata_d = d_wdata_i;
                    m_wstrb_d = d_wstrb_i;
                    if (if_req_i && (starve_q != CW'(STARVE_MAX))) begin
                        starve_d = starve_q + CW'(1);
                    end
                end
            end
            BUSY_I: begin
                if (done_evt) begin
                    state_d     = IDLE;
                    m_req_d     = 1'b0;
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = m_ack_i ? m_rdata_i : '0;
                end
            end
            BUSY_D: begin
                if (done_evt) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = (m_ack_i && !m_we_q) ? m_rdata_i : '0;
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_wstrb_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_wstrb_q   <= m_wstrb_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign m_req_o     = m_req_q;
    assign m_we_o      = m_we_q;
    assign m_addr_o    = m_addr_q;
    assign m_wdata_o   = m_wdata_q;
    assign m_wstrb_o   = m_wstrb_q;
    assign if_rvalid_o = if_rvalid_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, a scripted memory model
// that checks the bus payload, and a monitor that checks every response pulse.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SM  = 2;
    localparam int unsigned TMO = 8;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;     // ack in the lat-th m_req cycle; 0 = never ack
        logic [31:0] rdata;
    } mtx_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        err, err_sticky;

    resp_t resp_q[$];
    mtx_t  mem_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc_cnt = 0;
    bit    mem_busy = 1'b0;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(SM), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_wstrb_i(d_wstrb), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .m_req_o(m_req), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_wstrb_o(m_wstrb), .m_ack_i(m_ack), .m_rdata_i(m_rdata),
        .err_o(err), .err_sticky_o(err_sticky)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Memory model: pops the scripted transaction, checks the held payload, acks on schedule.
    initial begin
        mtx_t cur;
        int   mcyc;
        m_ack   = 1'b0;
        m_rdata = '0;
        mcyc    = 0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (reset) begin
                mem_busy = 1'b0;
            end else begin
                if (!mem_busy && m_req) begin
                    if (mem_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_m_req: got addr 0x%08h required no request", m_addr);
                    end else begin
                        cur      = mem_q.pop_front();
                        mem_busy = 1'b1;
                        mcyc     = 0;
                    end
                end
                if (mem_busy) begin
                    if (!m_req) begin
                        mem_busy = 1'b0;
                        if (cur.lat == 0) check("tmo_m_req_cycles", 32'(mcyc), 32'(TMO));
                        else check("m_req_dropped_early", 32'(mcyc), 32'(cur.lat));
                    end else begin
                        mcyc++;
                        check("m_addr", m_addr, cur.addr);
                        check("m_we", 32'(m_we), 32'(cur.we));
                        check("m_wstrb", 32'(m_wstrb), 32'(cur.wstrb));
                        if (cur.we) check("m_wdata", m_wdata, cur.wdata);
                        if (cur.lat != 0 && mcyc == cur.lat) begin
                            m_ack    = 1'b1;
                            m_rdata  = cur.rdata;
                            mem_busy = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Response monitor: every rvalid pulse pops and compares one scoreboard entry.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (if_rvalid && d_rvalid) check("both_rvalid", 32'(1), 32'(0));
                if (if_rvalid || d_rvalid) begin
                    if (resp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_rvalid: got if=%0b d=%0b required none", if_rvalid, d_rvalid);
                    end else begin
                        r = resp_q.pop_front();
                        check("rvalid_port", 32'(d_rvalid), 32'(r.is_d));
                        check("rdata", d_rvalid ? d_rdata : if_rdata, r.data);
                        check("err", 32'(err), 32'(r.err));
                        check("resp_cycle", 32'(cyc_cnt), 32'(r.cyc));
                    end
                end
            end
        end
    end

    task automatic fetch_req(input logic [31:0] addr, output int gc);
        int n = 0;
        gc = -1;
        if_req = 1'b1; if_addr = addr;
        while (gc < 0 && n < 100) begin
            @(negedge clk);
            if (if_gnt) gc = cyc_cnt;
            n++;
        end
        if (gc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL if_gnt_timeout: got no grant required grant within 100 cycles");
        end
        @(posedge clk); #1;
        if_req = 1'b0; if_addr = '0;
    endtask

    task automatic data_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output int gc);
        int n = 0;
        gc = -1;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
        while (gc < 0 && n < 100) begin
            @(negedge clk);
            if (d_gnt) gc = cyc_cnt;
            n++;
        end
        if (gc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL d_gnt_timeout: got no grant required grant within 100 cycles");
        end
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((resp_q.size() != 0 || mem_q.size() != 0 || mem_busy) && n < 200) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(n < 200), 32'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        int t0, gc, gci;
        int dexp[4];
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_req", 32'(m_req), 32'(0));
        check("rst_m_we", 32'(m_we), 32'(0));
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_m_wstrb", 32'(m_wstrb), 32'(0));
        check("rst_if_rvalid", 32'(if_rvalid), 32'(0));
        check("rst_d_rvalid", 32'(d_rvalid), 32'(0));
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_err_sticky", 32'(err_sticky), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Fetch alone, ack in the first m_req cycle.
        t0 = cyc_cnt;
        mem_q.push_back('{32'h100, 1'b0, 32'h0, 4'h0, 1, 32'h0000_0013});
        resp_q.push_back('{1'b0, 32'h0000_0013, 1'b0, t0 + 2});
        fetch_req(32'h100, gc);
        check("t1_if_gnt_cycle", 32'(gc), 32'(t0));
        wait_drain("t1");

        // Simultaneous fetch and data read: data first, fetch granted in the d_rvalid cycle.
        t0 = cyc_cnt;
        mem_q.push_back('{32'h2000, 1'b0, 32'h0, 4'h0, 4, 32'hDEAD_BEEF});
        mem_q.push_back('{32'h104, 1'b0, 32'h0, 4'h0, 1, 32'h0000_0093});
        resp_q.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0, t0 + 5});
        resp_q.push_back('{1'b0, 32'h0000_0093, 1'b0, t0 + 7});
        fork
            data_req(32'h2000, 1'b0, 32'h0, 4'h0, gc);
            fetch_req(32'h104, gci);
        join
        check("t2_d_gnt_cycle", 32'(gc), 32'(t0));
        check("t2_if_gnt_cycle", 32'(gci), 32'(t0 + 5));
        wait_drain("t2");

        // Starvation with STARVE_MAX=2: D, D, I, D, D.
        t0 = cyc_cnt;
        dexp[0] = 0; dexp[1] = 2; dexp[2] = 6; dexp[3] = 8;
        mem_q.push_back('{32'h3000, 1'b0, 32'h0, 4'h0, 1, 32'h0000_3000});
        mem_q.push_back('{32'h3004, 1'b0, 32'h0, 4'h0, 1, 32'h0000_3004});
        mem_q.push_back('{32'h200,  1'b0, 32'h0, 4'h0, 1, 32'h0000_0200});
        mem_q.push_back('{32'h3008, 1'b0, 32'h0, 4'h0, 1, 32'h0000_3008});
        mem_q.push_back('{32'h300C, 1'b0, 32'h0, 4'h0, 1, 32'h0000_300C});
        resp_q.push_back('{1'b1, 32'h0000_3000, 1'b0, t0 + 2});
        resp_q.push_back('{1'b1, 32'h0000_3004, 1'b0, t0 + 4});
        resp_q.push_back('{1'b0, 32'h0000_0200, 1'b0, t0 + 6});
        resp_q.push_back('{1'b1, 32'h0000_3008, 1'b0, t0 + 8});
        resp_q.push_back('{1'b1, 32'h0000_300C, 1'b0, t0 + 10});
        fork
            begin
                int g;
                for (int i = 0; i < 4; i++) begin
                    data_req(32'h3000 + 32'(4 * i), 1'b0, 32'h0, 4'h0, g);
                    check("t3_d_gnt_cycle", 32'(g), 32'(t0 + dexp[i]));
                end
            end
            begin
                int g;
                fetch_req(32'h200, g);
                check("t3_if_gnt_cycle", 32'(g), 32'(t0 + 4));
            end
        join
        wait_drain("t3");

        // Write: payload held until ack, write response carries zero data.
        t0 = cyc_cnt;
        mem_q.push_back('{32'h40, 1'b1, 32'hA5A5_A5A5, 4'b0011, 3, 32'hFFFF_FFFF});
        resp_q.push_back('{1'b1, 32'h0, 1'b0, t0 + 4});
        data_req(32'h40, 1'b1, 32'hA5A5_A5A5, 4'b0011, gc);
        check("t4_d_gnt_cycle", 32'(gc), 32'(t0));
        wait_drain("t4");

        // Reset in BUSY_D abandons the access without a response.
        mem_q.push_back('{32'h80, 1'b0, 32'h0, 4'h0, 50, 32'h1111_1111});
        data_req(32'h80, 1'b0, 32'h0, 4'h0, gc);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_m_req_after_reset", 32'(m_req), 32'(0));
        check("t5_d_rvalid_after_reset", 32'(d_rvalid), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        t0 = cyc_cnt;
        mem_q.push_back('{32'h84, 1'b0, 32'h0, 4'h0, 2, 32'hCAFE_F00D});
        resp_q.push_back('{1'b1, 32'hCAFE_F00D, 1'b0, t0 + 3});
        data_req(32'h84, 1'b0, 32'h0, 4'h0, gc);
        check("t5_fresh_d_gnt_cycle", 32'(gc), 32'(t0));
        wait_drain("t5");

`ifdef MEMARB_TIMEOUT_EN
        // Fetch never acked: m_req held TMO cycles, then an error response.
        t0 = cyc_cnt;
        mem_q.push_back('{32'h300, 1'b0, 32'h0, 4'h0, 0, 32'h0});
        resp_q.push_back('{1'b0, 32'h0, 1'b1, t0 + 1 + int'(TMO)});
        fetch_req(32'h300, gc);
        wait_drain("t6");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_err_sticky_held", 32'(err_sticky), 32'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_err_sticky_cleared", 32'(err_sticky), 32'(0));
`else
        @(negedge clk);
        check("err_sticky_tied_low", 32'(err_sticky), 32'(0));
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
